x_ctrl: RTL and testbench
=========================

X_CTRL -- requirements
Module: x_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-low.
REQ-003 pc  output  PROG_ADDR_W(10)  program counter, addresses program memory.
REQ-004 instruction  input  INSTR_W(32)  instruction at pc, valid combinationally in the same cycle.
REQ-005 data_sel  output  1  data bus access strobe for the current cycle.
REQ-006 data_we  output  1  1 = write, 0 = read; meaningful only when data_sel=1.
REQ-007 data_addr  output  ADDR_W(12)  data bus address.
REQ-008 data_to_rd  input  DATA_W(32)  read data, valid combinationally in the cycle data_sel=1 and data_we=0.
REQ-009 data_to_wr  output  DATA_W(32)  write data; always equals RA.

Function
REQ-010 Instruction format SHALL be opcode = instruction[31:28], imm = instruction[27:0]; all effective addresses use imm[ADDR_W-1:0].
REQ-011 Internal state SHALL be RA (accumulator, 32b), RB (pointer, 32b) and PC; every instruction completes in one cycle.
REQ-012 Opcodes: 0 NOP; 1 RDW RA=mem[imm]; 2 WRW mem[imm]=RA; 3 RDWB RA=mem[RB+imm]; 4 WRWB mem[RB+imm]=RA; 5 BEQI; 6 BEQ; 7 BNEQI; 8 BNEQ; 9 LDI; 10 LDIH; 11 ADD RA+=mem[imm]; 12 ADDI RA+=sext(imm); 13 SUB RA-=mem[imm]; 14 AND RA&=mem[imm]; 15 SHFT.
REQ-013 LDI SHALL load RA = sign-extended imm; LDIH SHALL set RA[31:16]=imm[15:0] and keep RA[15:0].
REQ-014 RB+imm SHALL be truncated to ADDR_W bits (wrap-around); arithmetic is modulo 2^32, no carry or overflow flag.
REQ-015 BEQI/BNEQI SHALL set PC=imm[9:0] when RA==0 (BEQI) or RA!=0 (BNEQI); otherwise PC=PC+1.
REQ-016 BEQ/BNEQ SHALL read mem[imm] and use data_to_rd[9:0] as target under the same conditions.
REQ-017 All other opcodes SHALL set PC=PC+1; PC wraps from 1023 to 0.
REQ-018 data_sel SHALL be 1 exactly for opcodes 1,2,3,4,6,8,11,13,14; data_we SHALL be 1 only for 2 and 4.
REQ-019 Address 1 SHALL be internal RB: RDW/WRW/ADD/SUB/AND at address 1 access RB, and data_sel SHALL be 0 for that cycle.
REQ-020 When data_sel=0, data_addr SHALL be 0 and data_we SHALL be 0.
REQ-021 Branch conditions SHALL use the RA value held before the current instruction.

Reset
REQ-022 While rst=0 at a clock edge: PC=0, RA=0, RB=0; data_sel, data_we and data_addr SHALL be 0 during reset.
REQ-023 Reset asserted mid-program SHALL abort the current instruction with no register update; execution restarts at PC=0 on the first edge after rst=1.

Configuration
REQ-024 With CTRL_SHFT_EN defined, SHFT SHALL perform RA = RA>>1 arithmetic when imm[27]=1 and RA = RA<<1 when imm[27]=0.
REQ-025 Without CTRL_SHFT_EN, opcode 15 SHALL execute as NOP with PC=PC+1.

Structure
REQ-026 Package x_ctrl_pkg SHALL hold DATA_W, INSTR_W, ADDR_W, PROG_ADDR_W, the opcode enumeration and the RB address constant (1).
REQ-027 One combinational sub-module x_ctrl_alu (add/sub/and/shift, RA next value) SHALL be used; decode and PC logic stay in x_ctrl.

Verification
REQ-028 Reset, then LDI 5; ADDI -2 -> RA=3, PC=2, data_sel=0 throughout.
REQ-029 LDI 0x1234; LDIH 0xABCD; WRW 0x100 -> data_sel=1, data_we=1, data_addr=0x100, data_to_wr=0xABCD1234.
REQ-030 WRW 1 with RA=0x10; RDWB 0x0F0, data_to_rd=7 -> data_sel=0 on the WRW cycle, data_addr=0x100 on the RDWB cycle, RA=7.
REQ-031 RA=0: BEQI 0x3FF then NOP -> PC=0x3FF then PC=0 (wrap); RA=1: BEQI 0x3FF -> PC=PC+1.
REQ-032 BNEQ 0x20 with RA=4 and data_to_rd=0x55 -> PC=0x55, data_we=0.
REQ-033 rst=0 during an ADD -> RA unchanged, PC=0 on the next cycle; SHFT with RA=0x80000000 and imm[27]=1 -> 0xC0000000 (CTRL_SHFT_EN defined) or unchanged (not defined).

Source files
------------

// File: rtl/x_ctrl_pkg.sv
// Shared widths, opcode encoding and helpers for the x_ctrl accumulator controller.
package x_ctrl_pkg;

    localparam int DATA_W      = 32;
    localparam int INSTR_W     = 32;
    localparam int ADDR_W      = 12;
    localparam int PROG_ADDR_W = 10;
    localparam int IMM_W       = 28;

    // Data address that maps onto the internal RB register instead of the bus.
    localparam logic [ADDR_W-1:0] RB_ADDR = 12'd1;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_RDW   = 4'd1,
        OP_WRW   = 4'd2,
        OP_RDWB  = 4'd3,
        OP_WRWB  = 4'd4,
        OP_BEQI  = 4'd5,
        OP_BEQ   = 4'd6,
        OP_BNEQI = 4'd7,
        OP_BNEQ  = 4'd8,
        OP_LDI   = 4'd9,
        OP_LDIH  = 4'd10,
        OP_ADD   = 4'd11,
        OP_ADDI  = 4'd12,
        OP_SUB   = 4'd13,
        OP_AND   = 4'd14,
        OP_SHFT  = 4'd15
    } opcode_t;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/x_ctrl_alu.sv
// Combinational next-value logic for the accumulator RA.
// SHFT is only implemented when CTRL_SHFT_EN is defined; otherwise it leaves RA alone.
module x_ctrl_alu
    import x_ctrl_pkg::*;
(
    input  opcode_t           op,
    input  logic [DATA_W-1:0] ra,
    input  logic [DATA_W-1:0] operand,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] ra_next
);

    always_comb begin
        ra_next = ra;
        case (op)
            OP_RDW, OP_RDWB: ra_next = operand;
            OP_LDI:          ra_next = sext_imm(imm);
            OP_LDIH:         ra_next = {imm[15:0], ra[15:0]};
            OP_ADD:          ra_next = ra + operand;
            OP_ADDI:         ra_next = ra + sext_imm(imm);
            OP_SUB:          ra_next = ra - operand;
            OP_AND:          ra_next = ra & operand;
`ifdef CTRL_SHFT_EN
            // imm[27] selects arithmetic right shift, otherwise left shift.
            OP_SHFT:         ra_next = imm[IMM_W-1] ? {ra[DATA_W-1], ra[DATA_W-1:1]}
                                                    : {ra[DATA_W-2:0], 1'b0};
`endif
            default:         ra_next = ra;
        endcase
    end

endmodule

// File: rtl/x_ctrl.sv
// Single-cycle accumulator controller: decode, PC sequencing, RB register and data bus.
// Optional SHFT instruction enabled by defining CTRL_SHFT_EN.
module x_ctrl
    import x_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    output logic [PROG_ADDR_W-1:0] pc,
    input  logic [INSTR_W-1:0]     instruction,
    output logic                   data_sel,
    output logic                   data_we,
    output logic [ADDR_W-1:0]      data_addr,
    input  logic [DATA_W-1:0]      data_to_rd,
    output logic [DATA_W-1:0]      data_to_wr
);

    logic [DATA_W-1:0]      ra;
    logic [DATA_W-1:0]      rb;
    logic [DATA_W-1:0]      ra_next;
    logic [DATA_W-1:0]      operand;
    logic [PROG_ADDR_W-1:0] pc_next;
    logic [IMM_W-1:0]       imm;
    logic [ADDR_W-1:0]      eff_addr;
    opcode_t                op;
    logic                   bus_op;
    logic                   rb_op;
    logic                   rb_hit;

    assign op  = opcode_t'(instruction[INSTR_W-1:INSTR_W-4]);
    assign imm = instruction[IMM_W-1:0];

    // Bus protocol: data_sel qualifies the cycle; data_we/data_addr are forced to 0
    // when it is low; read data is sampled combinationally in the same cycle.
    always_comb begin
        bus_op   = 1'b0;
        rb_op    = 1'b0;
        eff_addr = imm[ADDR_W-1:0];
        case (op)
            OP_RDW, OP_WRW, OP_ADD, OP_SUB, OP_AND: begin
                bus_op = 1'b1;
                rb_op  = 1'b1;
            end
            OP_RDWB, OP_WRWB: begin
                bus_op   = 1'b1;
                eff_addr = rb[ADDR_W-1:0] + imm[ADDR_W-1:0];
            end
            OP_BEQ, OP_BNEQ: bus_op = 1'b1;
            default: ;
        endcase
        rb_hit    = rb_op && (imm[ADDR_W-1:0] == RB_ADDR);
        data_sel  = rst && bus_op && !rb_hit;
        data_we   = data_sel && (op == OP_WRW || op == OP_WRWB);
        data_addr = data_sel ? eff_addr : '0;
        operand   = rb_hit ? rb : data_to_rd;
    end

    assign data_to_wr = ra;

    // Branch conditions look at RA as it stood before this instruction.
    always_comb begin
        pc_next = pc + 10'd1;
        case (op)
            OP_BEQI:  if (ra == '0) pc_next = imm[PROG_ADDR_W-1:0];
            OP_BEQ:   if (ra == '0) pc_next = data_to_rd[PROG_ADDR_W-1:0];
            OP_BNEQI: if (ra != '0) pc_next = imm[PROG_ADDR_W-1:0];
            OP_BNEQ:  if (ra != '0) pc_next = data_to_rd[PROG_ADDR_W-1:0];
            default: ;
        endcase
    end

    x_ctrl_alu u_alu (
        .op      (op),
        .ra      (ra),
        .operand (operand),
        .imm     (imm),
        .ra_next (ra_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= '0;
            ra <= '0;
            rb <= '0;
        end else begin
            pc <= pc_next;
            ra <= ra_next;
            if (op == OP_WRW && rb_hit) begin
                rb <= ra;
            end
        end
    end

endmodule

// File: tb/tb_x_ctrl.sv
// Randomized self-checking bench for x_ctrl with a behavioural instruction-level model.
module tb_x_ctrl;

    logic        clk;
    logic        rst;
    logic [9:0]  pc;
    logic [31:0] instruction;
    logic        data_sel;
    logic        data_we;
    logic [11:0] data_addr;
    logic [31:0] data_to_rd;
    logic [31:0] data_to_wr;

    x_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .instruction (instruction),
        .data_sel    (data_sel),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_to_rd  (data_to_rd),
        .data_to_wr  (data_to_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] bus_mem [4096];
    logic [31:0] ref_mem [4096];
    assign data_to_rd = bus_mem[data_addr];

    int unsigned m_pc;
    logic [31:0] m_ra;
    logic [31:0] m_rb;

    logic        last_sel;
    logic        last_we;
    logic [11:0] last_addr;

    int n_cmp;
    int n_bad;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One instruction cycle: drive, compare against the model, then advance both.
    task automatic step(input logic [31:0] ins, input logic r);
        int unsigned op;
        logic [27:0] imm;
        logic [31:0] sx;
        logic [31:0] rd;
        logic [31:0] n_ra;
        logic [31:0] n_rb;
        logic signed [31:0] s;
        int unsigned ea;
        int unsigned n_pc;
        bit to_rb;
        bit bus;
        bit e_we;
        bit mem_w;
        bit bus_w;
        logic [11:0] w_addr;
        logic [31:0] w_data;

        @(negedge clk);
        instruction = ins;
        rst = r;
        #1;
        op    = int'(ins[31:28]);
        imm   = ins[27:0];
        sx    = {{4{imm[27]}}, imm};
        ea    = (op == 3 || op == 4) ? (int'(m_rb % 4096) + int'(imm[11:0])) % 4096 : int'(imm[11:0]);
        to_rb = (op inside {1, 2, 11, 13, 14}) && imm[11:0] == 12'd1;
        bus   = r && (op inside {1, 2, 3, 4, 6, 8, 11, 13, 14}) && !to_rb;
        e_we  = bus && (op == 2 || op == 4);
        rd    = to_rb ? m_rb : ref_mem[ea];

        check_eq("pc", 32'(pc), 32'(m_pc));
        check_eq("data_sel", 32'(data_sel), 32'(bus));
        check_eq("data_we", 32'(data_we), 32'(e_we));
        check_eq("data_addr", 32'(data_addr), bus ? 32'(ea) : 32'd0);
        check_eq("data_to_wr", data_to_wr, m_ra);
        last_sel  = data_sel;
        last_we   = data_we;
        last_addr = data_addr;
        bus_w     = data_sel && data_we;
        w_addr    = data_addr;
        w_data    = data_to_wr;

        n_pc  = (m_pc + 1) % 1024;
        n_ra  = m_ra;
        n_rb  = m_rb;
        mem_w = 0;
        case (op)
            1, 3:  n_ra = rd;
            2, 4:  if (to_rb) n_rb = m_ra; else mem_w = 1;
            5:     if (m_ra == 0) n_pc = int'(imm[9:0]);
            6:     if (m_ra == 0) n_pc = int'(rd[9:0]);
            7:     if (m_ra != 0) n_pc = int'(imm[9:0]);
            8:     if (m_ra != 0) n_pc = int'(rd[9:0]);
            9:     n_ra = sx;
            10:    n_ra = {imm[15:0], m_ra[15:0]};
            11:    n_ra = m_ra + rd;
            12:    n_ra = m_ra + sx;
            13:    n_ra = m_ra - rd;
            14:    n_ra = m_ra & rd;
            15: begin
`ifdef CTRL_SHFT_EN
                s = m_ra;
                if (imm[27]) s = s >>> 1;
                else s = s <<< 1;
                n_ra = s;
`endif
            end
            default: ;
        endcase

        @(posedge clk);
        if (bus_w) bus_mem[w_addr] = w_data;
        if (!r) begin
            m_pc = 0;
            m_ra = '0;
            m_rb = '0;
        end else begin
            if (mem_w) ref_mem[ea] = m_ra;
            m_pc = n_pc;
            m_ra = n_ra;
            m_rb = n_rb;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [3:0]  op;
        logic [27:0] imm;
        op  = 4'($urandom_range(0, 15));
        imm = 28'($urandom);
        case ($urandom_range(0, 3))
            0:       imm[11:0] = 12'd1;
            1:       imm[11:0] = 12'($urandom_range(0, 15));
            default: ;
        endcase
        return {op, imm};
    endfunction

    function automatic logic [31:0] mk(input int unsigned op, input logic [27:0] imm);
        return {4'(op), imm};
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        instruction = '0;
        m_pc = 0;
        m_ra = '0;
        m_rb = '0;
        for (int i = 0; i < 4096; i++) begin
            bus_mem[i] = $urandom;
            ref_mem[i] = bus_mem[i];
        end

        step(mk(0, 0), 1'b0);
        step(mk(0, 0), 1'b0);
        check_eq("rst_pc", 32'(pc), 32'd0);
        check_eq("rst_ra", data_to_wr, 32'd0);

        step(mk(9, 28'd5), 1'b1);
        step(mk(12, 28'hFFFFFFE), 1'b1);
        check_eq("ldi_addi_ra", data_to_wr, 32'd3);
        check_eq("ldi_addi_pc", 32'(pc), 32'd2);

        step(mk(9, 28'h1234), 1'b1);
        step(mk(10, 28'hABCD), 1'b1);
        step(mk(2, 28'h100), 1'b1);
        check_eq("wrw_sel", 32'(last_sel), 32'd1);
        check_eq("wrw_we", 32'(last_we), 32'd1);
        check_eq("wrw_addr", 32'(last_addr), 32'h100);
        check_eq("wrw_data", bus_mem[12'h100], 32'hABCD1234);

        step(mk(9, 28'h10), 1'b1);
        step(mk(2, 28'd1), 1'b1);
        check_eq("wrw_rb_sel", 32'(last_sel), 32'd0);
        bus_mem[12'h100] = 32'd7;
        ref_mem[12'h100] = 32'd7;
        step(mk(3, 28'h0F0), 1'b1);
        check_eq("rdwb_addr", 32'(last_addr), 32'h100);
        check_eq("rdwb_ra", data_to_wr, 32'd7);

        step(mk(9, 28'd0), 1'b1);
        step(mk(5, 28'h3FF), 1'b1);
        check_eq("beqi_taken_pc", 32'(pc), 32'h3FF);
        step(mk(0, 0), 1'b1);
        check_eq("pc_wrap", 32'(pc), 32'd0);
        step(mk(9, 28'd1), 1'b1);
        step(mk(5, 28'h3FF), 1'b1);
        check_eq("beqi_not_taken_pc", 32'(pc), 32'd2);

        step(mk(9, 28'd4), 1'b1);
        bus_mem[12'h20] = 32'h55;
        ref_mem[12'h20] = 32'h55;
        step(mk(8, 28'h20), 1'b1);
        check_eq("bneq_pc", 32'(pc), 32'h55);
        check_eq("bneq_we", 32'(last_we), 32'd0);

        step(mk(9, 28'd0), 1'b1);
        bus_mem[12'h30] = 32'd9;
        ref_mem[12'h30] = 32'd9;
        step(mk(11, 28'h30), 1'b0);
        check_eq("rst_add_ra", data_to_wr, 32'd0);
        check_eq("rst_add_pc", 32'(pc), 32'd0);
        step(mk(0, 0), 1'b1);
        check_eq("restart_pc", 32'(pc), 32'd1);

        step(mk(10, 28'h8000), 1'b1);
        step(mk(15, 28'h8000000), 1'b1);
`ifdef CTRL_SHFT_EN
        check_eq("shft_asr", data_to_wr, 32'hC0000000);
`else
        check_eq("shft_nop", data_to_wr, 32'h80000000);
`endif

        for (int i = 0; i < 600; i++) begin
            step(rand_ins(), ($urandom_range(0, 39) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
